// File: rtl/pllcfgseq_pkg.sv
// Shared types and field widths for the PLL configuration sequencer.
package pllcfgseq_pkg;
    localparam int CLKR_W  = 6;
    localparam int CLKF_W  = 13;
    localparam int CLKOD_W = 4;
    localparam int BWADJ_W = 12;

    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, WAITLOCK, LOCKED, FAIL} pllseqstate_t;

    typedef struct packed {
        logic [CLKR_W-1:0]  clkr;
        logic [CLKF_W-1:0]  clkf;
        logic [CLKOD_W-1:0] clkod;
        logic [BWADJ_W-1:0] bwadj;
    } pllcfg_t;
endpackage

// File: rtl/pllcfgseq_sync.sv
// Two-flop synchronizer for a single asynchronous level signal.
module pllcfgseq_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic [1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[0], i_d};
    end

    assign o_q = r_sync[1];
endmodule

// File: rtl/pllcfgseq.sv
// PLL bring-up sequencer: shadow config, apply/settle/lock ordering,
// lock supervision with timeout, Moore status outputs.
module pllcfgseq
    import pllcfgseq_pkg::*;
#(
    parameter logic [CLKR_W-1:0]  DEF_CLKR      = 6'd1,
    parameter logic [CLKF_W-1:0]  DEF_CLKF      = 13'd32,
    parameter logic [CLKOD_W-1:0] DEF_CLKOD     = 4'd1,
    parameter logic [BWADJ_W-1:0] DEF_BWADJ     = 12'd16,
    parameter int                 SETTLE_CYCLES = 16,
    parameter int                 LOCK_TIMEOUT  = 1024,
    parameter int                 AUTOSTART     = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               CfgWrite,
    input  logic [CLKR_W-1:0]  CfgClkr,
    input  logic [CLKF_W-1:0]  CfgClkf,
    input  logic [CLKOD_W-1:0] CfgClkod,
    input  logic [BWADJ_W-1:0] CfgBwadj,
    input  logic               CfgStart,
    output logic               Busy,
    output logic               Done,
    output logic               Error,
    output logic [CLKR_W-1:0]  PLLclkr,
    output logic [CLKF_W-1:0]  PLLclkf,
    output logic [CLKOD_W-1:0] PLLclkod,
    output logic [BWADJ_W-1:0] PLLbwadj,
    output logic               PLLrfen,
    output logic               PLLfben,
    output logic               PLLfasten,
    output logic               PLLtest,
    input  logic               PLLlock,
    output logic               PLLconfigdone
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam pllcfg_t DEF_CFG = '{clkr: DEF_CLKR, clkf: DEF_CLKF, clkod: DEF_CLKOD, bwadj: DEF_BWADJ};

    pllseqstate_t   r_state, w_next;
    pllcfg_t        r_shadow, w_shadow, r_pll;
    logic [SW-1:0]  r_settle;
    logic [TW-1:0]  r_tmo;
    logic           r_auto;
    logic           r_busy, r_done, r_err, r_en, r_fasten, r_cfgdone;
    logic           w_lock;

    pllcfgseq_sync u_locksync (
        .clk (clk),
        .rst (reset),
        .i_d (PLLlock),
        .o_q (w_lock)
    );

    always_comb begin
        w_shadow = r_shadow;
        // Writes are only taken while idle-ish; a same-cycle start sees them.
        if (CfgWrite && !r_busy)
            w_shadow = '{clkr: CfgClkr, clkf: CfgClkf, clkod: CfgClkod, bwadj: CfgBwadj};

        w_next = r_state;
        case (r_state)
            IDLE:     if (CfgStart || r_auto) w_next = APPLY;
            APPLY:    w_next = SETTLE;
            SETTLE:   if (r_settle == '0) w_next = WAITLOCK;
            WAITLOCK: if (w_lock) w_next = LOCKED;
                      else if (r_tmo == '0) w_next = FAIL;
            LOCKED:   if (!w_lock) w_next = FAIL;
                      else if (CfgStart) w_next = APPLY;
            FAIL:     if (CfgStart) w_next = APPLY;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shadow  <= DEF_CFG;
            r_pll     <= DEF_CFG;
            r_settle  <= '0;
            r_tmo     <= '0;
            r_auto    <= (AUTOSTART != 0);
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_en      <= 1'b0;
            r_fasten  <= 1'b0;
            r_cfgdone <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_shadow <= w_shadow;
            // Auto-start only applies to the very first cycle out of reset.
            r_auto   <= 1'b0;
            if (w_next == APPLY) r_pll <= w_shadow;

            if (r_state == APPLY)
                r_settle <= SW'(SETTLE_CYCLES - 1);
            else if (r_state == SETTLE && r_settle != '0)
                r_settle <= r_settle - SW'(1);

            if (w_next == WAITLOCK && r_state != WAITLOCK)
                r_tmo <= TW'(LOCK_TIMEOUT - 1);
            else if (r_state == WAITLOCK && r_tmo != '0)
                r_tmo <= r_tmo - TW'(1);

            r_busy    <= (w_next == APPLY) || (w_next == SETTLE) || (w_next == WAITLOCK);
            r_done    <= (w_next == LOCKED);
            r_err     <= (w_next == FAIL);
            r_en      <= (w_next == SETTLE) || (w_next == WAITLOCK) || (w_next == LOCKED);
            r_fasten  <= (w_next == SETTLE) || (w_next == WAITLOCK);
            r_cfgdone <= (w_next == LOCKED);
        end
    end

    assign Busy          = r_busy;
    assign Done          = r_done;
    assign Error         = r_err;
    assign PLLclkr       = r_pll.clkr;
    assign PLLclkf       = r_pll.clkf;
    assign PLLclkod      = r_pll.clkod;
    assign PLLbwadj      = r_pll.bwadj;
    assign PLLrfen       = r_en;
    assign PLLfben       = r_en;
    assign PLLfasten     = r_fasten;
    assign PLLtest       = 1'b0;
    assign PLLconfigdone = r_cfgdone;
endmodule

// File: tb/tb_pllcfgseq.sv
// Bench for pllcfgseq: directed vector table, reset corner case, then
// randomized sequences checked against a timing-arithmetic reference model.
module tb_pllcfgseq;
    localparam int S = 4;
    localparam int T = 8;

    // {Busy,Done,Error,rfen,fben,fasten,test,configdone}
    localparam logic [7:0] F_IDLE = 8'h00;
    localparam logic [7:0] F_APP  = 8'h80;
    localparam logic [7:0] F_SET  = 8'h9C;
    localparam logic [7:0] F_LCK  = 8'h59;
    localparam logic [7:0] F_ERR  = 8'h20;

    // {clkr,clkf,clkod,bwadj}
    localparam logic [34:0] D  = {6'd1, 13'd32, 4'd1, 12'd16};
    localparam logic [34:0] W7 = {6'd7, 13'd99, 4'd9, 12'd99};
    localparam logic [34:0] WN = {6'd3, 13'd50, 4'd2, 12'd20};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        CfgWrite = 1'b0, CfgStart = 1'b0, PLLlock = 1'b0;
    logic [5:0]  CfgClkr = '0;
    logic [12:0] CfgClkf = '0;
    logic [3:0]  CfgClkod = '0;
    logic [11:0] CfgBwadj = '0;
    logic        Busy, Done, Error, PLLrfen, PLLfben, PLLfasten, PLLtest, PLLconfigdone;
    logic [5:0]  PLLclkr;
    logic [12:0] PLLclkf;
    logic [3:0]  PLLclkod;
    logic [11:0] PLLbwadj;

    int n_chk = 0;
    int n_fail = 0;

    pllcfgseq #(
        .DEF_CLKR(6'd1), .DEF_CLKF(13'd32), .DEF_CLKOD(4'd1), .DEF_BWADJ(12'd16),
        .SETTLE_CYCLES(S), .LOCK_TIMEOUT(T), .AUTOSTART(1)
    ) dut (
        .clk(clk), .reset(reset),
        .CfgWrite(CfgWrite), .CfgClkr(CfgClkr), .CfgClkf(CfgClkf),
        .CfgClkod(CfgClkod), .CfgBwadj(CfgBwadj), .CfgStart(CfgStart),
        .Busy(Busy), .Done(Done), .Error(Error),
        .PLLclkr(PLLclkr), .PLLclkf(PLLclkf), .PLLclkod(PLLclkod), .PLLbwadj(PLLbwadj),
        .PLLrfen(PLLrfen), .PLLfben(PLLfben), .PLLfasten(PLLfasten), .PLLtest(PLLtest),
        .PLLlock(PLLlock), .PLLconfigdone(PLLconfigdone)
    );

    always #5 clk = ~clk;

    wire [7:0]  w_flags = {Busy, Done, Error, PLLrfen, PLLfben, PLLfasten, PLLtest, PLLconfigdone};
    wire [34:0] w_cfg   = {PLLclkr, PLLclkf, PLLclkod, PLLbwadj};

    typedef struct {
        logic        w, s, l;
        logic [34:0] cfg;
        logic [7:0]  ef;
        logic [34:0] ec;
        string       nm;
    } vec_t;
    vec_t tbl[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [34:0] act, input logic [34:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic row(input int n, input logic w, input logic s, input logic l,
                       input logic [34:0] cfg, input logic [7:0] ef, input logic [34:0] ec,
                       input string nm);
        vec_t v;
        v.w = w; v.s = s; v.l = l; v.cfg = cfg; v.ef = ef; v.ec = ec; v.nm = nm;
        repeat (n) tbl.push_back(v);
    endtask

    task automatic drive(input logic w, input logic s, input logic l, input logic [34:0] cfg);
        CfgWrite = w;
        CfgStart = s;
        PLLlock  = l;
        {CfgClkr, CfgClkf, CfgClkod, CfgBwadj} = cfg;
    endtask

    initial begin
        logic [34:0] m_shadow;
        logic [63:0] r64;

        row(1,  0,0,0, D,  F_APP, D,  "auto_apply");
        row(1,  0,0,0, D,  F_SET, D,  "settle");
        row(1,  1,0,0, W7, F_SET, D,  "busy_write_drop");
        row(2,  0,0,0, D,  F_SET, D,  "settle");
        row(3,  0,0,0, D,  F_SET, D,  "waitlock");
        row(2,  0,0,1, D,  F_SET, D,  "lock_sync_delay");
        row(2,  0,0,1, D,  F_LCK, D,  "locked");
        row(1,  0,1,1, D,  F_APP, D,  "restart_def_clkr");
        row(5,  0,0,1, D,  F_SET, D,  "settle2");
        row(1,  0,0,1, D,  F_LCK, D,  "locked2");
        row(1,  1,1,1, WN, F_APP, WN, "write_start_apply");
        row(1,  0,0,1, D,  F_SET, WN, "settle3");
        row(1,  0,1,1, D,  F_SET, WN, "busy_start_ignored");
        row(3,  0,0,1, D,  F_SET, WN, "settle3");
        row(1,  0,0,1, D,  F_LCK, WN, "locked3");
        row(2,  0,0,0, D,  F_LCK, WN, "lock_drop_delay");
        row(2,  0,0,0, D,  F_ERR, WN, "lock_lost");
        row(1,  0,1,0, D,  F_APP, WN, "retry_apply");
        row(12, 0,0,0, D,  F_SET, WN, "timeout_wait");
        row(1,  0,0,0, D,  F_ERR, WN, "timeout_fail");

        // Reset state
        #12;
        chk("reset_flags", 35'(w_flags), 35'(F_IDLE));
        chk("reset_cfg", w_cfg, D);
        tick();
        reset = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].w, tbl[i].s, tbl[i].l, tbl[i].cfg);
            tick();
            chk({tbl[i].nm, "_flags"}, 35'(w_flags), 35'(tbl[i].ef));
            chk({tbl[i].nm, "_cfg"}, w_cfg, tbl[i].ec);
        end

        // Reset asserted mid-WAITLOCK, then autostart on release
        drive(0, 1, 0, D);
        tick();
        CfgStart = 1'b0;
        repeat (S + 1) tick();
        chk("pre_reset_waitlock", 35'(w_flags), 35'(F_SET));
        #3 reset = 1'b1;
        #1;
        chk("async_reset_flags", 35'(w_flags), 35'(F_IDLE));
        chk("async_reset_cfg", w_cfg, D);
        tick();
        reset = 1'b0;
        tick();
        chk("post_reset_apply", 35'(w_flags), 35'(F_APP));
        chk("post_reset_cfg", w_cfg, D);
        repeat (S + 1 + T) tick();
        chk("post_reset_timeout", 35'(w_flags), 35'(F_ERR));

        // Randomized sequences: outcome and timing derived from the lock edge
        m_shadow = D;
        for (int t = 0; t < 30; t++) begin
            int cl, cs, cw, e;
            bit dw, lk;
            logic [34:0] nc;
            drive(0, 0, 0, D);
            repeat (3) tick();
            chk("rnd_pre_fail", 35'(w_flags), 35'(F_ERR));
            dw = 1'($urandom_range(0, 1));
            r64 = {$urandom, $urandom};
            nc = r64[34:0];
            cl = (t == 0) ? S + T - 1 : (t == 1) ? S + T : int'($urandom_range(1, S + T + 3));
            cs = $urandom_range(1, S + 1);
            cw = $urandom_range(1, S + 1);
            // Lock sampled at edge cl is seen by the FSM at cl+2; WAITLOCK
            // evaluates edges S+2 .. S+1+T.
            e  = (cl + 2 > S + 2) ? cl + 2 : S + 2;
            lk = (e <= S + 1 + T);
            if (!lk) e = S + 1 + T;
            if (dw) m_shadow = nc;
            for (int c = 0; c <= e + 1; c++) begin
                logic [7:0] ef;
                r64 = {$urandom, $urandom};
                drive((c == 0 && dw) || (c == cw), (c == 0) || (c == cs), (c >= cl),
                      (c == 0) ? nc : r64[34:0]);
                tick();
                if (c == 0)      ef = F_APP;
                else if (c < e)  ef = F_SET;
                else             ef = lk ? F_LCK : F_ERR;
                chk("rnd_flags", 35'(w_flags), 35'(ef));
                chk("rnd_cfg", w_cfg, m_shadow);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
